// File: rtl/inet_checksum_stream.sv
// inet_checksum_stream
//   Streaming RFC 1071 ones'-complement checksum engine. It takes 1, 2 or 4
//   bytes per cycle, accepts partial words, and handles any byte alignment
//   and odd packet lengths. Packets are framed by start / in_done.
//
//   Optional feature macro: INET_CHECKSUM_VERIFY_EN adds the `ok` output.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   start       1-cycle pulse: clear accumulator, begin a new packet
//   inclk       input word valid this cycle
//   in          data word, first byte in the MSBs
//   in_nbytes   valid bytes in `in` (MSB-aligned), 0 = no-op, clamped to IN_BYTES
//   in_done     end of packet; may coincide with the last inclk
//   busy        high from the cycle after start until outclk
//   outclk      1-cycle pulse: out (and ok) valid
//   out         ~(folded sum), held until the next outclk
//   ok          (macro only) folded sum == 16'hFFFF, registered with outclk
module inet_checksum_stream #(
  parameter  int IN_BYTES = 1,
  localparam int NBW      = $clog2(IN_BYTES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inclk,
  input  logic [IN_BYTES*8-1:0] in,
  input  logic [NBW-1:0]        in_nbytes,
  input  logic                  in_done,
  output logic                  busy,
  output logic                  outclk,
  output logic [15:0]           out
`ifdef INET_CHECKSUM_VERIFY_EN
  ,
  output logic                  ok
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, FOLD, EMIT} state_t;

  state_t      state_q, state_d;
  logic [16:0] acc_q,   acc_d;
  logic        phase_q, phase_d;
  logic [15:0] out_q,   out_d;
`ifdef INET_CHECKSUM_VERIFY_EN
  logic        ok_q,    ok_d;
`endif

  // start restarts the packet in the same cycle, so a word presented with
  // start is placed as byte 0 of the new packet.
  logic [16:0] acc_base;
  logic        phase_base;
  assign acc_base   = start ? 17'd0 : acc_q;
  assign phase_base = start ? 1'b0  : phase_q;

  logic [NBW-1:0] nb_eff;
  assign nb_eff = (in_nbytes > NBW'(IN_BYTES)) ? NBW'(IN_BYTES) : in_nbytes;

  // Each byte lands in the high half of a 16-bit lane when its global
  // position is even, the low half when odd; masked bytes contribute zero.
  logic [IN_BYTES-1:0][15:0] lane_val;
  for (genvar i = 0; i < IN_BYTES; i++) begin : g_lane
    localparam bit ODD = (i % 2) == 1;
    logic [7:0] b;
    logic       hi;
    assign b  = (NBW'(i) < nb_eff) ? in[(IN_BYTES-1-i)*8 +: 8] : 8'h00;
    assign hi = (phase_base == ODD);
    assign lane_val[i] = hi ? {b, 8'h00} : {8'h00, b};
  end

  // acc <= 0x10002 and at most 2 high + 2 low lanes keep the sum in 18 bits.
  logic [17:0] sum;
  logic [16:0] sum_fold;
  always_comb begin
    sum = {1'b0, acc_base};
    for (int i = 0; i < IN_BYTES; i++) sum = sum + 18'(lane_val[i]);
    sum_fold = {1'b0, sum[15:0]} + 17'(sum[17:16]);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    out_d   = out_q;
`ifdef INET_CHECKSUM_VERIFY_EN
    ok_d    = ok_q;
`endif
    if (start || state_q == ACCUM) begin
      state_d = in_done ? FOLD : ACCUM;
      acc_d   = acc_base;
      phase_d = phase_base;
      if (inclk) begin
        acc_d   = sum_fold;
        phase_d = phase_base ^ nb_eff[0];
      end
`ifdef INET_CHECKSUM_VERIFY_EN
      if (start) ok_d = 1'b0;
`endif
    end else begin
      case (state_q)
        // acc <= 0x10002 here, so one end-around fold always lands below 2^16.
        FOLD: begin
          acc_d   = {1'b0, acc_q[15:0]} + 17'(acc_q[16]);
          state_d = EMIT;
        end
        EMIT: begin
          out_d   = ~acc_q[15:0];
`ifdef INET_CHECKSUM_VERIFY_EN
          ok_d    = (acc_q[15:0] == 16'hFFFF);
`endif
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      phase_q <= 1'b0;
      out_q   <= '0;
`ifdef INET_CHECKSUM_VERIFY_EN
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      out_q   <= out_d;
`ifdef INET_CHECKSUM_VERIFY_EN
      ok_q    <= ok_d;
`endif
    end
  end

  // A start or rst landing on the EMIT cycle aborts the packet, so the pulse
  // is gated; the result is shown directly while pulsing and then held.
  assign outclk = (state_q == EMIT) && !start && !rst;
  assign busy   = (state_q != IDLE);
  assign out    = outclk ? ~acc_q[15:0] : out_q;
`ifdef INET_CHECKSUM_VERIFY_EN
  assign ok     = outclk ? (acc_q[15:0] == 16'hFFFF) : ok_q;
`endif

endmodule

// File: tb/tb_inet_checksum_stream.sv
// Bench for inet_checksum_stream: one instance each at IN_BYTES = 1, 2, 4.
module tb_inet_checksum_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a[3], inclk_a[3], done_a[3];
  logic        outclk_a[3], busy_a[3];
  logic [15:0] out_a[3];
  logic [7:0]  in1;
  logic [15:0] in2;
  logic [31:0] in4;
  logic [0:0]  nb1;
  logic [1:0]  nb2;
  logic [2:0]  nb4;
`ifdef INET_CHECKSUM_VERIFY_EN
  logic        ok_a[3];
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int oc_cnt[3] = '{0, 0, 0};

  inet_checksum_stream #(.IN_BYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[0]), .inclk(inclk_a[0]), .in(in1),
    .in_nbytes(nb1), .in_done(done_a[0]), .busy(busy_a[0]),
    .outclk(outclk_a[0]), .out(out_a[0])
`ifdef INET_CHECKSUM_VERIFY_EN
    , .ok(ok_a[0])
`endif
  );
  inet_checksum_stream #(.IN_BYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[1]), .inclk(inclk_a[1]), .in(in2),
    .in_nbytes(nb2), .in_done(done_a[1]), .busy(busy_a[1]),
    .outclk(outclk_a[1]), .out(out_a[1])
`ifdef INET_CHECKSUM_VERIFY_EN
    , .ok(ok_a[1])
`endif
  );
  inet_checksum_stream #(.IN_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_a[2]), .inclk(inclk_a[2]), .in(in4),
    .in_nbytes(nb4), .in_done(done_a[2]), .busy(busy_a[2]),
    .outclk(outclk_a[2]), .out(out_a[2])
`ifdef INET_CHECKSUM_VERIFY_EN
    , .ok(ok_a[2])
`endif
  );

  // Count outclk pulses just before each rising edge (inputs move on negedges).
  always @(negedge clk) begin
    #4;
    for (int d = 0; d < 3; d++) if (outclk_a[d]) oc_cnt[d]++;
  end

  typedef struct {
    logic [191:0] data;   // packet bytes right-aligned, byte 0 most significant
    int           len;
    logic [15:0]  exp;
    string        name;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [IN_BYTES=%0d] got %h want %h", nm, 1 << d, act, exp);
    end
  endtask

  task automatic set_word(input int d, input logic [31:0] w, input logic [2:0] nb);
    case (d)
      0:       begin in1 = w[7:0];  nb1 = nb[0:0]; end
      1:       begin in2 = w[15:0]; nb2 = nb[1:0]; end
      default: begin in4 = w;       nb4 = nb;      end
    endcase
  endtask

  // Starts a packet and streams it in full words (last one partial).
  // now: start in the current cycle; fws: first word rides with start.
  // Returns at the negedge after the last word's edge.
  task automatic feed(input int d, input logic [191:0] data, input int len,
                      input bit now, input bit fws, input bit with_done);
    int wb = 1 << d;
    int nw = (len + wb - 1) / wb;
    if (!now) @(negedge clk);
    start_a[d] = 1'b1;
    if (!fws) begin @(negedge clk); start_a[d] = 1'b0; end
    if (len == 0) begin done_a[d] = with_done; @(negedge clk); end
    for (int i = 0; i < nw; i++) begin
      logic [31:0] w;
      int nb;
      w = '0; nb = 0;
      for (int b = 0; b < wb; b++)
        if (i*wb + b < len) begin
          w[(wb-1-b)*8 +: 8] = data[(len-1-(i*wb+b))*8 +: 8];
          nb++;
        end
      set_word(d, w, 3'(nb));
      inclk_a[d] = 1'b1;
      done_a[d]  = with_done && (i == nw - 1);
      @(negedge clk);
      start_a[d] = 1'b0;
    end
    start_a[d] = 1'b0; inclk_a[d] = 1'b0; done_a[d] = 1'b0;
  endtask

  // Called in the cycle after in_done: expects outclk exactly one cycle later.
  task automatic expect_res(input int d, input string nm, input logic [15:0] exp,
                            input bit junk);
    if (junk) begin set_word(d, 32'hFFFF_FFFF, 3'd7); inclk_a[d] = 1'b1; end
    #1 chk({nm, " outclk_early"}, d, 32'(outclk_a[d]), 32'd0);
    @(negedge clk);
    #1 chk({nm, " outclk"}, d, 32'(outclk_a[d]), 32'd1);
    chk({nm, " out"}, d, 32'(out_a[d]), 32'(exp));
`ifdef INET_CHECKSUM_VERIFY_EN
    chk({nm, " ok"}, d, 32'(ok_a[d]), 32'(exp == 16'h0000));
`endif
    @(negedge clk);
    inclk_a[d] = 1'b0;
    #1 chk({nm, " outclk_pulse"}, d, 32'(outclk_a[d]), 32'd0);
    chk({nm, " out_held"}, d, 32'(out_a[d]), 32'(exp));
    chk({nm, " busy_after"}, d, 32'(busy_a[d]), 32'd0);
  endtask

  localparam logic [191:0] T1 = 192'h45000166718a00008011000000000000ffffffff;

  initial begin
    int c0;
    vt[0] = '{T1, 20, 16'hC7FD, "hdr"};
    vt[1] = '{192'h45000166718a00008011c7fd00000000ffffffff, 20, 16'h0000, "hdr_ok"};
    vt[2] = '{192'h46000166718a00008011c7fd00000000ffffffff, 20, 16'hFEFF, "hdr_bad"};
    vt[3] = '{192'h010203, 3, 16'hFBFD, "odd3"};
    vt[4] = '{192'hffff0001, 4, 16'hFFFE, "carry"};
    vt[5] = '{192'h0, 0, 16'hFFFF, "empty"};
    vt[6] = '{192'hffffffffffff, 6, 16'h0000, "zero_res"};
    vt[7] = '{192'hab, 1, 16'h54FF, "one_byte"};
    vt[8] = '{192'h123456789a, 5, 16'hFD52, "five"};
    vt[9] = '{192'h01020304050607, 7, 16'hEFF3, "seven"};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_a[d] = 1'b0; inclk_a[d] = 1'b0; done_a[d] = 1'b0;
    end
    in1 = '0; in2 = '0; in4 = '0; nb1 = '0; nb2 = '0; nb4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst outclk", d, 32'(outclk_a[d]), 32'd0);
      chk("rst busy",   d, 32'(busy_a[d]),   32'd0);
      chk("rst out",    d, 32'(out_a[d]),    32'd0);
`ifdef INET_CHECKSUM_VERIFY_EN
      chk("rst ok",     d, 32'(ok_a[d]),     32'd0);
`endif
    end

    // Table vectors at every width.
    for (int d = 0; d < 3; d++)
      for (int v = 0; v < 10; v++) begin
        feed(d, vt[v].data, vt[v].len, 1'b0, 1'b0, 1'b1);
        expect_res(d, vt[v].name, vt[v].exp, 1'b0);
      end

    // Partial words with garbage in masked bytes; 01 02 03 -> FBFD.
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    set_word(0, 32'h01, 3'd1); inclk_a[0] = 1'b1;
    @(negedge clk); set_word(0, 32'hEE, 3'd0);
    @(negedge clk); set_word(0, 32'h02, 3'd1);
    @(negedge clk); set_word(0, 32'h03, 3'd1); done_a[0] = 1'b1;
    @(negedge clk); inclk_a[0] = 1'b0; done_a[0] = 1'b0;
    expect_res(0, "partial", 16'hFBFD, 1'b0);

    @(negedge clk); start_a[1] = 1'b1;
    @(negedge clk); start_a[1] = 1'b0;
    set_word(1, 32'h01EE, 3'd1); inclk_a[1] = 1'b1;
    @(negedge clk); set_word(1, 32'h0203, 3'd2); done_a[1] = 1'b1;
    @(negedge clk); inclk_a[1] = 1'b0; done_a[1] = 1'b0;
    expect_res(1, "partial", 16'hFBFD, 1'b0);

    @(negedge clk); start_a[2] = 1'b1;
    @(negedge clk); start_a[2] = 1'b0;
    set_word(2, 32'h01EEEEEE, 3'd1); inclk_a[2] = 1'b1;
    @(negedge clk); set_word(2, 32'h0203EEEE, 3'd2); done_a[2] = 1'b1;
    @(negedge clk); inclk_a[2] = 1'b0; done_a[2] = 1'b0;
    expect_res(2, "partial", 16'hFBFD, 1'b0);

    // in_nbytes above IN_BYTES is clamped (byte parity follows the clamp).
    @(negedge clk); start_a[1] = 1'b1;
    @(negedge clk); start_a[1] = 1'b0;
    set_word(1, 32'h1234, 3'd3); inclk_a[1] = 1'b1;
    @(negedge clk); set_word(1, 32'h56EE, 3'd1); done_a[1] = 1'b1;
    @(negedge clk); inclk_a[1] = 1'b0; done_a[1] = 1'b0;
    expect_res(1, "clamp", 16'h97CB, 1'b0);

    @(negedge clk); start_a[2] = 1'b1;
    @(negedge clk); start_a[2] = 1'b0;
    set_word(2, 32'h12345678, 3'd7); inclk_a[2] = 1'b1;
    @(negedge clk); set_word(2, 32'h9AEEEEEE, 3'd1); done_a[2] = 1'b1;
    @(negedge clk); inclk_a[2] = 1'b0; done_a[2] = 1'b0;
    expect_res(2, "clamp", 16'hFD52, 1'b0);

    for (int d = 0; d < 3; d++) begin
      // Abort in ACCUM: 10 bytes, restart, full header -> one outclk.
      c0 = oc_cnt[d];
      feed(d, 192'h45000166718a00008011, 10, 1'b0, 1'b0, 1'b0);
      feed(d, T1, 20, 1'b0, 1'b0, 1'b1);
      expect_res(d, "abort_accum", 16'hC7FD, 1'b0);
      chk("abort_accum count", d, 32'(oc_cnt[d] - c0), 32'd1);

      // Abort in FOLD.
      c0 = oc_cnt[d];
      feed(d, 192'hffff0001, 4, 1'b0, 1'b0, 1'b1);
      feed(d, T1, 20, 1'b1, 1'b0, 1'b1);
      expect_res(d, "abort_fold", 16'hC7FD, 1'b0);
      chk("abort_fold count", d, 32'(oc_cnt[d] - c0), 32'd1);

      // Abort in EMIT.
      c0 = oc_cnt[d];
      feed(d, 192'hffff0001, 4, 1'b0, 1'b0, 1'b1);
      feed(d, T1, 20, 1'b0, 1'b0, 1'b1);
      expect_res(d, "abort_emit", 16'hC7FD, 1'b0);
      chk("abort_emit count", d, 32'(oc_cnt[d] - c0), 32'd1);

      // First word rides with start.
      feed(d, 192'hffff0001, 4, 1'b0, 1'b1, 1'b1);
      expect_res(d, "start_inclk", 16'hFFFE, 1'b0);

      // start + in_done together closes a fresh empty packet.
      feed(d, 192'h1234, 2, 1'b0, 1'b0, 1'b0);
      feed(d, 192'h0, 0, 1'b0, 1'b1, 1'b1);
      expect_res(d, "start_done", 16'hFFFF, 1'b0);

      // Words offered while busy are ignored.
      feed(d, T1, 20, 1'b0, 1'b0, 1'b1);
      expect_res(d, "busy_inclk", 16'hC7FD, 1'b1);
    end

    // rst during FOLD: no pulse, outputs back to reset values.
    c0 = oc_cnt[1];
    feed(1, T1, 20, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_fold out",    d, 32'(out_a[d]),    32'd0);
      chk("rst_fold busy",   d, 32'(busy_a[d]),   32'd0);
      chk("rst_fold outclk", d, 32'(outclk_a[d]), 32'd0);
    end
    repeat (4) @(negedge clk);
    chk("rst_fold count", 1, 32'(oc_cnt[1] - c0), 32'd0);

    // rst on the EMIT cycle also suppresses the pulse.
    c0 = oc_cnt[2];
    feed(2, T1, 20, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b1;
    #1 chk("rst_emit outclk", 2, 32'(outclk_a[2]), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_emit count", 2, 32'(oc_cnt[2] - c0), 32'd0);
    chk("rst_emit out", 2, 32'(out_a[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
